// File: rtl/muldiv_ctrl_pkg.sv
// Shared op codes, state encoding and signed-magnitude multiply helpers for muldiv_ctrl.
package muldiv_ctrl_pkg;

  localparam int MULDIV_OP_WD  = 2;
  localparam int MULDIV_RES_WD = 64;

  localparam logic [MULDIV_OP_WD-1:0] MULDIV_OP_MULT  = 2'b00;
  localparam logic [MULDIV_OP_WD-1:0] MULDIV_OP_MULTU = 2'b01;
  localparam logic [MULDIV_OP_WD-1:0] MULDIV_OP_DIV   = 2'b10;
  localparam logic [MULDIV_OP_WD-1:0] MULDIV_OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MULDIV_IDLE = 2'd0,
    MULDIV_MUL  = 2'd1,
    MULDIV_DIV  = 2'd2,
    MULDIV_DONE = 2'd3
  } muldiv_state_t;

  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction

  // Multiply magnitudes, then restore the sign when the operand signs differ.
  function automatic logic [MULDIV_RES_WD-1:0] mul_result(input logic sgn,
                                                          input logic [31:0] a,
                                                          input logic [31:0] b);
    logic [MULDIV_RES_WD-1:0] p;
    p = 64'(magnitude(a, sgn)) * 64'(magnitude(b, sgn));
    return (sgn && (a[31] ^ b[31])) ? -p : p;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_mul_iter.sv
// Radix-2 shift-add multiplier, MUL_CYCLES iterations after start; done flags the last iteration.
// Only instantiated when MULDIV_MUL_ITER_EN is defined.
module muldiv_ctrl_mul_iter
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     signed_op,
  input  logic [31:0]              opa,
  input  logic [31:0]              opb,
  output logic [MULDIV_RES_WD-1:0] product,
  output logic                     done
);

  logic [MULDIV_RES_WD-1:0] acc_reg;
  logic [MULDIV_RES_WD-1:0] mcand_reg;
  logic [MULDIV_RES_WD-1:0] acc_next;
  logic [31:0]              mplier_reg;
  logic [5:0]               cnt_reg;
  logic                     neg_reg;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : 64'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
    end else if (start) begin
      acc_reg    <= '0;
      mcand_reg  <= {32'd0, magnitude(opa, signed_op)};
      mplier_reg <= magnitude(opb, signed_op);
      cnt_reg    <= 6'(MUL_CYCLES);
      neg_reg    <= signed_op && (opa[31] ^ opb[31]);
    end else if (cnt_reg != 6'd0) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg - 6'd1;
    end
  end

  // The final partial product is folded in combinationally so the caller can register it on done.
  assign done    = (cnt_reg == 6'd1);
  assign product = neg_reg ? -acc_next : acc_next;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: accepts one request, drives the shared divider, stalls EX until done.
// Build option MULDIV_MUL_ITER_EN selects the iterative multiplier instead of the single-cycle product.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  input  logic [MULDIV_OP_WD-1:0]  req_op_i,
  input  logic [31:0]              src1_i,
  input  logic [31:0]              src2_i,
  output logic                     stallreq_o,
  output logic                     res_valid_o,
  output logic [31:0]              res_hi_o,
  output logic [31:0]              res_lo_o,
  output logic                     div_start_o,
  output logic                     div_signed_o,
  output logic [31:0]              div_opdata1_o,
  output logic [31:0]              div_opdata2_o,
  output logic                     div_annul_o,
  input  logic [MULDIV_RES_WD-1:0] div_result_i,
  input  logic                     div_ready_i
);

  muldiv_state_t            state_reg;
  logic                     op_signed_reg;
  logic [31:0]              src1_reg;
  logic [31:0]              src2_reg;
  logic [31:0]              hi_reg;
  logic [31:0]              lo_reg;
  logic                     accept;
  logic                     req_is_mul;
  logic                     req_signed;
  logic                     mul_done;
  logic [MULDIV_RES_WD-1:0] mul_product;

  if (MUL_CYCLES < 1 || MUL_CYCLES > 63) begin : g_bad_mul_cycles
    $error("muldiv_ctrl: MUL_CYCLES must fit the 6-bit iteration counter");
  end

  assign req_is_mul = (req_op_i == MULDIV_OP_MULT) || (req_op_i == MULDIV_OP_MULTU);
  assign req_signed = (req_op_i == MULDIV_OP_MULT) || (req_op_i == MULDIV_OP_DIV);
  assign accept     = (state_reg == MULDIV_IDLE) && req_valid_i && !flush_i && !rst;

`ifdef MULDIV_MUL_ITER_EN
  muldiv_ctrl_mul_iter #(.MUL_CYCLES(MUL_CYCLES)) u_mul_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && req_is_mul),
    .signed_op (req_signed),
    .opa       (src1_i),
    .opb       (src2_i),
    .product   (mul_product),
    .done      (mul_done)
  );
`else
  assign mul_product = mul_result(op_signed_reg, src1_reg, src2_reg);
  assign mul_done    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= MULDIV_IDLE;
      op_signed_reg <= 1'b0;
      src1_reg      <= '0;
      src2_reg      <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
    end else begin
      case (state_reg)
        MULDIV_IDLE: begin
          if (req_valid_i && !flush_i) begin
            op_signed_reg <= req_signed;
            src1_reg      <= src1_i;
            src2_reg      <= src2_i;
            if (req_is_mul) begin
              state_reg <= MULDIV_MUL;
            end else if (src2_i != 32'd0) begin
              state_reg <= MULDIV_DIV;
            end else begin
              // Divide by zero never reaches the divider and yields zeros.
              hi_reg    <= '0;
              lo_reg    <= '0;
              state_reg <= MULDIV_DONE;
            end
          end
        end
        MULDIV_MUL: begin
          if (flush_i) begin
            state_reg <= MULDIV_IDLE;
          end else if (mul_done) begin
            {hi_reg, lo_reg} <= mul_product;
            state_reg        <= MULDIV_DONE;
          end
        end
        MULDIV_DIV: begin
          if (flush_i) begin
            state_reg <= MULDIV_IDLE;
          end else if (div_ready_i) begin
            {hi_reg, lo_reg} <= div_result_i;
            state_reg        <= MULDIV_DONE;
          end
        end
        default: state_reg <= MULDIV_IDLE;
      endcase
    end
  end

  // Flush suppresses the stall, start and strobe in the same cycle it arrives.
  assign stallreq_o    = accept || (((state_reg == MULDIV_MUL) || (state_reg == MULDIV_DIV)) && !flush_i);
  assign res_valid_o   = (state_reg == MULDIV_DONE) && !flush_i;
  assign div_start_o   = (state_reg == MULDIV_DIV) && !flush_i;
  assign div_annul_o   = (state_reg == MULDIV_DIV) && flush_i;
  assign div_signed_o  = (state_reg == MULDIV_DIV) && op_signed_reg;
  assign div_opdata1_o = src1_reg;
  assign div_opdata2_o = src2_reg;
  assign res_hi_o      = hi_reg;
  assign res_lo_o      = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed table-driven bench for muldiv_ctrl with a behavioural 33-cycle divider model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

`ifdef MULDIV_MUL_ITER_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        stallreq, res_valid, div_start, div_signed, div_annul;
  logic [31:0] res_hi, res_lo, div_opdata1, div_opdata2;
  logic [63:0] div_result;
  logic        div_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .req_valid_i   (req_valid),
    .req_op_i      (req_op),
    .src1_i        (src1),
    .src2_i        (src2),
    .stallreq_o    (stallreq),
    .res_valid_o   (res_valid),
    .res_hi_o      (res_hi),
    .res_lo_o      (res_lo),
    .div_start_o   (div_start),
    .div_signed_o  (div_signed),
    .div_opdata1_o (div_opdata1),
    .div_opdata2_o (div_opdata2),
    .div_annul_o   (div_annul),
    .div_result_i  (div_result),
    .div_ready_i   (div_ready)
  );

  // Behavioural divider: ready one cycle, 33 cycles after start is first seen.
  logic dm_busy = 1'b0;
  logic dm_ready = 1'b0;
  int   dm_cnt = 0;
  logic [63:0] dm_res = '0;
  assign div_ready  = dm_ready;
  assign div_result = dm_res;

  always @(posedge clk) begin
    if (rst || div_annul) begin
      dm_busy  <= 1'b0;
      dm_ready <= 1'b0;
    end else if (dm_ready) begin
      dm_ready <= 1'b0;
    end else if (dm_busy) begin
      if (dm_cnt == 0) begin
        dm_ready <= 1'b1;
        dm_busy  <= 1'b0;
      end else begin
        dm_cnt <= dm_cnt - 1;
      end
    end else if (div_start) begin
      dm_busy <= 1'b1;
      dm_cnt  <= 32;
      if (div_signed)
        dm_res <= {32'($signed(div_opdata1) % $signed(div_opdata2)),
                   32'($signed(div_opdata1) / $signed(div_opdata2))};
      else
        dm_res <= {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
    end
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int lat);
    int   n;
    int   stall_cycles;
    logic saw_start;
    logic exp_start;
    n = 0;
    stall_cycles = 0;
    saw_start = 1'b0;
    exp_start = op[1] && (b != 32'd0);
    req_valid = 1'b1;
    req_op = op;
    src1 = a;
    src2 = b;
    #1;
    check({name, " accept_stall"}, stallreq, 1'b1);
    while (1) begin
      tick();
      n++;
      saw_start |= div_start;
      if (res_valid) break;
      stall_cycles += int'(stallreq);
      if (n > 200) begin
        check({name, " timeout"}, 1'b0, 1'b1);
        break;
      end
    end
    req_valid = 1'b0;
    if (lat >= 0) check({name, " latency"}, n, lat);
    check({name, " hi"}, res_hi, hi);
    check({name, " lo"}, res_lo, lo);
    check({name, " stall_until_done"}, stall_cycles, n - 1);
    check({name, " stall_in_done"}, stallreq, 1'b0);
    check({name, " start_in_done"}, div_start, 1'b0);
    check({name, " start_used"}, saw_start, exp_start);
    $display("op %s a=%h b=%h -> hi=%h lo=%h after %0d cycles", name, a, b, res_hi, res_lo, n);
    tick();
    check({name, " strobe_one_cycle"}, res_valid, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " stallreq"}, stallreq, 1'b0);
    check({name, " res_valid"}, res_valid, 1'b0);
    check({name, " res_hi"}, res_hi, 32'd0);
    check({name, " res_lo"}, res_lo, 32'd0);
    check({name, " div_start"}, div_start, 1'b0);
    check({name, " div_signed"}, div_signed, 1'b0);
    check({name, " div_annul"}, div_annul, 1'b0);
    check({name, " opdata1"}, div_opdata1, 32'd0);
    check({name, " opdata2"}, div_opdata2, 32'd0);
  endtask

  initial begin
    vecs[0] = '{"MULT -2x3",     MULDIV_OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT};
    vecs[1] = '{"MULTU max^2",   MULDIV_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
    vecs[2] = '{"MULT 7x-5",     MULDIV_OP_MULT,  32'd7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, MUL_LAT};
    vecs[3] = '{"MULT -3x-4",    MULDIV_OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C, MUL_LAT};
    vecs[4] = '{"MULTU 2^31x2",  MULDIV_OP_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, MUL_LAT};
    vecs[5] = '{"DIV -7/2",      MULDIV_OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, -1};
    vecs[6] = '{"DIVU 100/7",    MULDIV_OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       -1};
    vecs[7] = '{"DIVU 5/0",      MULDIV_OP_DIVU,  32'd5,        32'd0,        32'd0,        32'd0,        1};
    vecs[8] = '{"DIV 8/0",       MULDIV_OP_DIV,   32'd8,        32'd0,        32'd0,        32'd0,        1};

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("after_reset");

    // Table vectors, applied back to back (each request presented the cycle after DONE)
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);

    // Request and flush together in IDLE: not accepted
    req_valid = 1'b1; req_op = MULDIV_OP_MULT; src1 = 32'd3; src2 = 32'd4; flush = 1'b1;
    #1;
    check("idle_flush stall", stallreq, 1'b0);
    tick();
    req_valid = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush not_busy", stallreq, 1'b0);
    tick();
    check("idle_flush no_result", res_valid, 1'b0);
    $display("req+flush in IDLE: request dropped");

    // Flush 10 cycles after accepting a divide
    req_valid = 1'b1; req_op = MULDIV_OP_DIVU; src1 = 32'd100; src2 = 32'd7;
    for (int c = 0; c < 10; c++) tick();
    check("flush_div in_div", div_start, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_div annul", div_annul, 1'b1);
    check("flush_div start_low", div_start, 1'b0);
    check("flush_div stall_low", stallreq, 1'b0);
    check("flush_div no_valid", res_valid, 1'b0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    check("flush_div annul_pulse", div_annul, 1'b0);
    check("flush_div idle", stallreq, 1'b0);
    begin
      logic seen_valid;
      seen_valid = 1'b0;
      for (int c = 0; c < 40; c++) begin
        tick();
        seen_valid |= res_valid | div_start;
      end
      check("flush_div quiet", seen_valid, 1'b0);
    end
    $display("flush during DIV: annulled, no result");
    run_op("MULTU 6x7", MULDIV_OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT);

    // Flush arriving with divider ready: result discarded
    req_valid = 1'b1; req_op = MULDIV_OP_DIVU; src1 = 32'd9; src2 = 32'd2;
    begin
      int n;
      n = 0;
      while (!div_ready && n < 100) begin
        tick();
        n++;
      end
      check("flush_ready seen_ready", div_ready, 1'b1);
    end
    flush = 1'b1;
    #1;
    check("flush_ready annul", div_annul, 1'b1);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    check("flush_ready no_valid", res_valid, 1'b0);
    check("flush_ready hi_kept", res_hi, 32'd0);
    check("flush_ready lo_kept", res_lo, 32'd42);
    $display("flush with div_ready: result discarded");

    // Reset in the middle of a multiply
    req_valid = 1'b1; req_op = MULDIV_OP_MULTU; src1 = 32'd3; src2 = 32'd5;
    tick();
    check("rst_mid busy", stallreq, 1'b1);
    rst = 1'b1; req_valid = 1'b0;
    tick();
    check_all_zero("rst_mid");
    rst = 1'b0;
    tick();
    check("rst_mid abandoned", res_valid, 1'b0);
    $display("reset mid-MUL: outputs cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
